// File: rtl/qsn_pkg.sv
// Shared constants, types and rotation helper for the forward and inverse QSN.
package qsn_pkg;

    localparam int LiftingFactor = 4;
    localparam int ShiftWidth    = $clog2(LiftingFactor);
    localparam int Depth         = 4;

    typedef logic [LiftingFactor-1:0] word_t;
    typedef logic [ShiftWidth-1:0]    shift_t;

    typedef enum logic {
        ROT_FWD = 1'b0,
        ROT_INV = 1'b1
    } rot_dir_e;

    // Forward: O[i] = I[(i+s) mod Z]; inverse: O[i] = I[(i-s) mod Z].
    // The index wraps through shift_t, which is exact because Z is a power of two.
    function automatic word_t rotate(input word_t w, input shift_t s, input rot_dir_e dir);
        word_t  r;
        shift_t idx;
        r = '0;
        for (int i = 0; i < LiftingFactor; i++) begin
            idx  = (dir == ROT_FWD) ? shift_t'(i) + s : shift_t'(i) - s;
            r[i] = w[idx];
        end
        return r;
    endfunction

endpackage

// File: rtl/qsn_inv_fifo.sv
// Depth x LiftingFactor first-word-fall-through FIFO with sticky overflow/underflow.
module qsn_inv_fifo
    import qsn_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  word_t push_data,
    input  logic  pop,
    output word_t head,
    output logic  full,
    output logic  empty,
    output logic  overflow,
    output logic  underflow,
    output logic  push_accept,
    output logic  pop_accept
);

    localparam int PtrWidth = $clog2(Depth);
    localparam int CntWidth = PtrWidth + 1;

    typedef logic [PtrWidth-1:0] ptr_t;
    typedef logic [CntWidth-1:0] cnt_t;

    localparam cnt_t DepthCnt = cnt_t'(Depth);

    word_t mem_q [Depth];
    word_t mem_d [Depth];
    ptr_t  wr_ptr_q, wr_ptr_d;
    ptr_t  rd_ptr_q, rd_ptr_d;
    cnt_t  count_q, count_d;
    logic  overflow_q, overflow_d;
    logic  underflow_q, underflow_d;

    assign full      = (count_q == DepthCnt);
    assign empty     = (count_q == '0);
    assign head      = mem_q[rd_ptr_q];
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // A push into a full FIFO still lands when a pop frees the head slot in the same cycle.
    always_comb begin
        push_accept = push & (~full | pop);
        pop_accept  = pop & ~empty;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push_accept) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + ptr_t'(1);
        end
        if (pop_accept) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        count_d     = count_q + cnt_t'(push_accept) - cnt_t'(pop_accept);
        overflow_d  = overflow_q | (push & full & ~pop);
        underflow_d = underflow_q | (pop & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: rtl/tt_um_qsn_inv.sv
// TinyTapeout top: strobe-driven inverse QSN feeding a FWFT result FIFO.
// Define QSN_INV_STATS_EN to expose accepted push/pop counters on uio_out.
module tt_um_qsn_inv
    import qsn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Strobes reset high so a pin held high through reset never looks like a rising edge.
    localparam logic [7:0] SyncResetVal = 8'hC0;

    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;
    logic [1:0] prev_q, prev_d;
    logic [7:0] uo_q, uo_d;

    word_t  rot_word;
    word_t  unrot_word;
    word_t  head;
    word_t  head_shown;
    shift_t shift;
    logic   push_evt, pop_evt;
    logic   full, empty, overflow, underflow;
    logic   push_accept, pop_accept;
    logic   unused_ok;

    always_comb begin
        sync1_d    = ui_in;
        sync2_d    = sync1_q;
        prev_d     = sync2_q[7:6];
        rot_word   = '0;
        for (int k = 0; k < LiftingFactor; k++) begin
            rot_word[k] = sync2_q[LiftingFactor-1-k];
        end
        shift      = {sync2_q[4], sync2_q[5]};
        push_evt   = sync2_q[6] & ~prev_q[0];
        pop_evt    = sync2_q[7] & ~prev_q[1];
        unrot_word = rotate(rot_word, shift, ROT_INV);
    end

    qsn_inv_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push_evt),
        .push_data   (unrot_word),
        .pop         (pop_evt),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .underflow   (underflow),
        .push_accept (push_accept),
        .pop_accept  (pop_accept)
    );

    // Head word appears on the pins bit-reversed and is blanked while the FIFO is empty.
    always_comb begin
        head_shown = empty ? word_t'(0) : head;
        uo_d       = {overflow, underflow, ~full, ~empty, 4'b0000};
        for (int k = 0; k < LiftingFactor; k++) begin
            uo_d[LiftingFactor-1-k] = head_shown[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= SyncResetVal;
            sync2_q <= SyncResetVal;
            prev_q  <= 2'b11;
            uo_q    <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            uo_q    <= uo_d;
        end
    end

    assign uo_out = uo_q;

`ifdef QSN_INV_STATS_EN
    logic [3:0] push_cnt_q, push_cnt_d;
    logic [3:0] pop_cnt_q, pop_cnt_d;

    always_comb begin
        push_cnt_d = push_cnt_q + {3'b000, push_accept};
        pop_cnt_d  = pop_cnt_q + {3'b000, pop_accept};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
        end else begin
            push_cnt_q <= push_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
        end
    end

    assign uio_out   = {push_cnt_q, pop_cnt_q};
    assign uio_oe    = 8'hFF;
    assign unused_ok = &{1'b0, ena, uio_in};
`else
    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = &{1'b0, ena, uio_in, push_accept, pop_accept};
`endif

endmodule

// File: tb/tb_tt_um_qsn_inv.sv
// Self-checking bench for tt_um_qsn_inv against a queue-based reference model.
module tb_tt_um_qsn_inv;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    // Reference model state: queue of original sub-blocks plus sticky flags.
    logic [3:0] model_q [$];
    logic       model_ovf;
    logic       model_udf;
    int         model_push_cnt;
    int         model_pop_cnt;

    tt_um_qsn_inv dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic [3:0] fwdRot(input logic [3:0] w, input int s);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = w[(i + s) % 4];
        return r;
    endfunction

    function automatic logic [7:0] expUo();
        logic [7:0] e;
        e = {model_ovf, model_udf, model_q.size() != DEPTH, model_q.size() != 0, 4'b0000};
        if (model_q.size() != 0) e[3:0] = bitrev4(model_q[0]);
        return e;
    endfunction

    function automatic logic [7:0] expUio();
`ifdef QSN_INV_STATS_EN
        logic [7:0] e;
        e = {model_push_cnt[3:0], model_pop_cnt[3:0]};
        return e;
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [7:0] expOe();
`ifdef QSN_INV_STATS_EN
        return 8'hFF;
`else
        return 8'h00;
`endif
    endfunction

    task automatic modelStep(input logic [3:0] word, input logic push, input logic pop);
        if (push && pop) begin
            if (model_q.size() == 0) begin
                model_q.push_back(word);
                model_push_cnt++;
                model_udf = 1'b1;
            end else begin
                void'(model_q.pop_front());
                model_q.push_back(word);
                model_push_cnt++;
                model_pop_cnt++;
            end
        end else if (push) begin
            if (model_q.size() == DEPTH) model_ovf = 1'b1;
            else begin
                model_q.push_back(word);
                model_push_cnt++;
            end
        end else if (pop) begin
            if (model_q.size() == 0) model_udf = 1'b1;
            else begin
                void'(model_q.pop_front());
                model_pop_cnt++;
            end
        end
    endtask

    task automatic resetDut(input logic [7:0] hold);
        @(negedge clk);
        ui_in = hold;
        #2 rst_n = 1'b0;
        #1 checkOutput("uo_in_reset", uo_out, 8'h00);
        model_q.delete();
        model_ovf      = 1'b0;
        model_udf      = 1'b0;
        model_push_cnt = 0;
        model_pop_cnt  = 0;
        checkOutput("uio_in_reset", uio_out, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Word w is the original sub-block; the bench rotates it forward before driving the pins.
    task automatic applyStimulus(input logic [3:0] w, input logic [1:0] s, input logic push, input logic pop);
        logic [7:0] u;
        u[3:0] = bitrev4(fwdRot(w, int'(s)));
        u[4]   = s[1];
        u[5]   = s[0];
        u[6]   = push;
        u[7]   = pop;
        @(negedge clk);
        ui_in = u;
        repeat (3) @(negedge clk);
        ui_in = {2'b00, u[5:0]};
        repeat (3) @(negedge clk);
        modelStep(w, push, pop);
        checkOutput($sformatf("uo_w%0h_s%0d_p%0d%0d", w, s, push, pop), uo_out, expUo());
        checkOutput("uio_out", uio_out, expUio());
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'h00;

        $display("[TB] reset with push strobe held high");
        resetDut(8'h40);
        checkOutput("rst_idle", uo_out, 8'h20);
        checkOutput("uio_oe", uio_oe, expOe());
        ui_in = 8'h00;
        repeat (4) @(negedge clk);
        checkOutput("rst_nopush", uo_out, 8'h20);

        $display("[TB] single push latency");
        @(negedge clk);
        ui_in = 8'h61;
        repeat (3) @(negedge clk);
        checkOutput("lat3_valid", {7'b0, uo_out[4]}, 8'h00);
        @(negedge clk);
        checkOutput("lat4_word", uo_out, 8'h38);
        ui_in = 8'h21;
        repeat (3) @(negedge clk);
        modelStep(4'b0001, 1'b1, 1'b0);
        applyStimulus(4'h0, 2'd0, 1'b0, 1'b1);

        $display("[TB] all words x all shifts round trip");
        for (int w = 0; w < 16; w++) begin
            for (int s = 0; s < 4; s++) begin
                applyStimulus(4'(w), 2'(s), 1'b1, 1'b0);
                applyStimulus(4'h0, 2'd0, 1'b0, 1'b1);
            end
        end

        $display("[TB] overflow and underflow");
        resetDut(8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(4'(3 * i + 1), 2'(i), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(4'h0, 2'd0, 1'b0, 1'b1);

        $display("[TB] simultaneous push and pop on full and empty");
        resetDut(8'h00);
        applyStimulus(4'h9, 2'd2, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(4'(i + 5), 2'(i), 1'b1, 1'b0);
        applyStimulus(4'hE, 2'd3, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(4'h0, 2'd0, 1'b0, 1'b1);

        $display("[TB] reset mid-operation discards contents");
        applyStimulus(4'hA, 2'd1, 1'b1, 1'b0);
        applyStimulus(4'h5, 2'd3, 1'b1, 1'b0);
        resetDut(8'h00);
        checkOutput("rst_discard", uo_out, expUo());

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            applyStimulus(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                          kind != 2, kind >= 2);
        end
        checkOutput("uio_oe_end", uio_oe, expOe());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
